cvxif_dotp_unit: RTL and testbench
==================================

# cvxif_dotp_unit

CV-X-IF coprocessor attached downstream of the CVA6 core's issue stage. Configured for RV32, CvxifEn=1, single commit port, four scoreboard entries. Accepts custom-0 instructions carrying packed int8 operands, computes 4-lane dot products and ReLU in a two-stage pipeline, and returns results through a small skid/result buffer. Used to accelerate MNIST inference kernels without enabling an FPU.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 supported
- IdWidth, 3, instruction id width; must cover 4 scoreboard entries plus margin
- ResBufDepth, 2, result buffer entries; power of two, ≥2

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock; asynchronous, active-low
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  issue request accepted this cycle
- issue_instr_i  in  32  instruction word
- issue_id_i  in  IdWidth  instruction id
- issue_rs1_i, issue_rs2_i  in  XLEN  source operands
- issue_rs_valid_i  in  2  operand valid flags
- issue_accept_o  out  1  instruction is ours; valid with issue_ready_o
- issue_writeback_o  out  1  will write rd; equals issue_accept_o
- commit_valid_i  in  1  commit/kill strobe
- commit_id_i  in  IdWidth  id being committed
- commit_kill_i  in  1  1 = discard id, 0 = commit
- result_valid_o  out  1  result available
- result_ready_i  in  1  core takes result
- result_id_o  out  IdWidth  id of result
- result_data_o  out  XLEN  rd value
- result_rd_o  out  5  destination register
- result_we_o  out  1  register write enable; always 1 when result_valid_o

## Operation
- Decode: opcode 7'b0001011, funct7 0. funct3: 0 DOTP4 signed, 1 DOTP4U unsigned, 2 RELU (rd = rs1 < 0 ? 0 : rs1), 3 DOTP4S (macro-gated). Anything else: issue_accept_o=0, still handshaken.
- Issue handshake: issue_ready_o=1 when both rs_valid bits set and in-flight count (pipeline + buffer) < ResBufDepth. Non-matching instrs: issue_ready_o=1 whenever rs_valid, accept=0.
- DOTP4: sum of rs1[8i+7:8i]*rs2[8i+7:8i], i=0..3; products 16-bit (signed or unsigned), sum sign/zero-extended to 32 bits; no overflow possible.
- Stage 1 registers four products, id, rd, op. Stage 2 registers sum/ReLU into result buffer entry.
- Each in-flight entry carries a committed and a killed flag. commit_valid_i matching entry id sets one of them, in any stage, including same cycle as entry moves stages.
- Killed entries are dropped at buffer head without asserting result_valid_o, freeing the slot next cycle.
- result_valid_o only for head entry with committed=1. The core commits before or after issue; both orders handled.
- Result held stable while result_valid_o && !result_ready_i.
- Pipeline advances whenever buffer has space; stalls hold stage registers.

## Timing
- Reset: issue_ready_o=0 until first edge after deassert, then per rules; result_valid_o=0, all buffer entries invalid, data outputs 0.
- Latency: issue accept at cycle N → result_valid_o earliest N+2 if already committed.
- Throughput: one instr/cycle with result_ready_i held 1 and commits prompt.
- Full: ResBufDepth in flight → issue_ready_o=0 same cycle (combinational from count, not from issue_valid_i).
- Simultaneous result pop and issue accept when full: accept allowed (count uses pop).
- Commit for an id not in flight: ignored.
- Reset mid-operation: all entries lost; no result emitted afterwards.

## Configuration
- CVXIF_DOTP_SAT_EN defined: funct3=3 accepted; DOTP4S = signed DOTP4 clamped to [-128, 127], result sign-extended.
- Undefined: funct3=3 rejected (accept=0); no saturation logic synthesized.

## Structure
- Package cvxif_dotp_pkg: opcode/funct3 constants, op_e enum, in-flight entry struct (id, rd, op, committed, killed, data).
- Sub-module cvxif_dotp_datapath: stage 1 multipliers, stage 2 adder tree/ReLU/clamp; top keeps decode, handshakes, buffer, commit tracking.

## Test plan
- DOTP4 rs1=0xFF02FF01, rs2=0x01030102, committed at issue → result 0xFFFFFFFF+... exact: (1·2)+(-1·1)+(2·3)+(-1·1)=6 → result_data_o=6, two cycles after accept.
- DOTP4U same operands → 1·2+255·1+2·3+255·1=518 (0x206).
- RELU rs1=0x80000000 → 0; rs1=0x12345678 → 0x12345678.
- Issue 3 instrs, result_ready_i=0: third sees issue_ready_o=0 until first pop; data order preserved.
- Kill id 1 of ids 0,1,2 → results 0 and 2 only, ids in order.
- With CVXIF_DOTP_SAT_EN, DOTP4S rs1=rs2=0x7F7F7F7F → 127; without macro → issue_accept_o=0.

Source files
------------

// File: rtl/cvxif_dotp_pkg.sv
// Shared constants and types for the CV-X-IF int8 dot-product coprocessor.
package cvxif_dotp_pkg;

  localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] F7_DOTP     = 7'd0;
  localparam logic [2:0] F3_DOTP4    = 3'd0;
  localparam logic [2:0] F3_DOTP4U   = 3'd1;
  localparam logic [2:0] F3_RELU     = 3'd2;
  localparam logic [2:0] F3_DOTP4S   = 3'd3;

  // Ids are stored at a fixed width so the entry struct needs no parameter.
  localparam int unsigned ID_MAX_W = 8;

  typedef enum logic [1:0] {
    OP_DOTP4  = 2'd0,
    OP_DOTP4U = 2'd1,
    OP_RELU   = 2'd2,
    OP_DOTP4S = 2'd3
  } op_e;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [4:0]          rd;
    op_e                 op;
    logic                committed;
    logic                killed;
    logic [31:0]         data;
  } entry_t;

  // Fold a commit/kill strobe into an in-flight entry when the ids match.
  function automatic entry_t apply_commit(entry_t e, logic v,
                                          logic [ID_MAX_W-1:0] id, logic kill);
    entry_t r;
    r = e;
    if (v && (e.id == id)) begin
      if (kill) r.killed    = 1'b1;
      else      r.committed = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cvxif_dotp_datapath.sv
// Two-stage int8 datapath: stage 1 registers four lane products and rs1,
// stage 2 (combinational, captured by the caller) sums, applies ReLU or clamp.
// Clamp logic exists only when CVXIF_DOTP_SAT_EN is defined.
module cvxif_dotp_datapath
  import cvxif_dotp_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        i_ld,
  input  op_e         i_op,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  op_e         i_s2_op,
  output logic [31:0] o_res
);

  logic [3:0][15:0] w_prod;
  logic [3:0][15:0] r_prod;
  logic [31:0]      r_rs1;
  logic [31:0]      w_sum;
  logic             w_sgn;
  logic             w_s2_sgn;

  assign w_sgn    = (i_op != OP_DOTP4U);
  assign w_s2_sgn = (i_s2_op != OP_DOTP4U);

  // Extending to 16 bits first makes the low product bits exact for both signednesses.
  for (genvar g = 0; g < 4; g++) begin : g_lane
    logic [15:0] w_a, w_b;
    assign w_a       = {{8{w_sgn & i_rs1[8*g+7]}}, i_rs1[8*g +: 8]};
    assign w_b       = {{8{w_sgn & i_rs2[8*g+7]}}, i_rs2[8*g +: 8]};
    assign w_prod[g] = w_a * w_b;
  end

  // Stage 1 register; holds while the pipeline is stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_prod <= '0;
      r_rs1  <= '0;
    end else if (i_ld) begin
      r_prod <= w_prod;
      r_rs1  <= i_rs1;
    end
  end

  // Stage 2: extend and sum products, then pick ReLU / clamped result.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < 4; i++)
      w_sum = w_sum + {{16{w_s2_sgn & r_prod[i][15]}}, r_prod[i]};
    o_res = w_sum;
    if (i_s2_op == OP_RELU) begin
      o_res = r_rs1[31] ? 32'd0 : r_rs1;
    end
`ifdef CVXIF_DOTP_SAT_EN
    else if (i_s2_op == OP_DOTP4S) begin
      if ($signed(w_sum) > 32'sd127)       o_res = 32'd127;
      else if ($signed(w_sum) < -32'sd128) o_res = 32'hFFFF_FF80;
    end
`endif
  end

endmodule

// File: rtl/cvxif_dotp_unit.sv
// CV-X-IF coprocessor top: decode, issue/result handshakes, stage-1 entry,
// result buffer and commit/kill tracking. Optional macro: CVXIF_DOTP_SAT_EN
// (enables DOTP4S, funct3=3, saturating signed dot product).
module cvxif_dotp_unit
  import cvxif_dotp_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int IdWidth     = 3,
  parameter int ResBufDepth = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [31:0]        issue_instr_i,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic [XLEN-1:0]    issue_rs1_i,
  input  logic [XLEN-1:0]    issue_rs2_i,
  input  logic [1:0]         issue_rs_valid_i,
  output logic               issue_accept_o,
  output logic               issue_writeback_o,
  input  logic               commit_valid_i,
  input  logic [IdWidth-1:0] commit_id_i,
  input  logic               commit_kill_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic [4:0]         result_rd_o,
  output logic               result_we_o
);

  localparam int PTR_W = (ResBufDepth > 1) ? $clog2(ResBufDepth) : 1;
  localparam int CNT_W = $clog2(ResBufDepth) + 2;

  logic                r_rdy_en;
  logic                r_s1_vld;
  entry_t              r_s1;
  entry_t              r_buf [ResBufDepth];
  logic [PTR_W-1:0]    r_wp, r_rp;
  logic [CNT_W-1:0]    r_cnt;

  logic [2:0]          w_f3;
  logic                w_match;
  logic                w_issue;
  logic [ID_MAX_W-1:0] w_iid, w_cid;
  entry_t              w_s1_new, w_buf_new, w_hd;
  logic                w_hvld, w_pop_out, w_drop, w_pop;
  logic                w_buf_space, w_s1_move, w_s1_free;
  logic [CNT_W-1:0]    w_inflight;
  logic [31:0]         w_res;

  assign w_f3  = issue_instr_i[14:12];
  assign w_iid = ID_MAX_W'(issue_id_i);
  assign w_cid = ID_MAX_W'(commit_id_i);

  // Decode: only custom-0 with funct7=0 and a supported funct3 is ours.
  always_comb begin
    w_match = 1'b0;
    if (issue_instr_i[6:0] == OPC_CUSTOM0 && issue_instr_i[31:25] == F7_DOTP) begin
      case (w_f3)
        F3_DOTP4, F3_DOTP4U, F3_RELU: w_match = 1'b1;
`ifdef CVXIF_DOTP_SAT_EN
        F3_DOTP4S: w_match = 1'b1;
`endif
        default: w_match = 1'b0;
      endcase
    end
  end

  // Buffer head, pop/drop and occupancy. A delivered pop frees its slot for
  // issue in the same cycle; a dropped (killed) head only frees it next cycle.
  always_comb begin
    w_hd        = r_buf[r_rp];
    w_hvld      = (r_cnt != '0);
    w_pop_out   = w_hvld && w_hd.committed && !w_hd.killed && result_ready_i;
    w_drop      = w_hvld && w_hd.killed;
    w_pop       = w_pop_out || w_drop;
    w_buf_space = (r_cnt < CNT_W'(ResBufDepth)) || w_pop;
    w_s1_move   = r_s1_vld && w_buf_space;
    w_s1_free   = !r_s1_vld || w_buf_space;
    w_inflight  = r_cnt + CNT_W'(r_s1_vld) - CNT_W'(w_pop_out);
  end

  assign issue_ready_o     = r_rdy_en && (&issue_rs_valid_i) &&
                             (!w_match || ((w_inflight < CNT_W'(ResBufDepth)) && w_s1_free));
  assign issue_accept_o    = w_match;
  assign issue_writeback_o = w_match;
  assign w_issue           = issue_valid_i && issue_ready_o && w_match;

  // New stage-1 entry; a commit in the issue cycle lands on it directly.
  always_comb begin
    w_s1_new           = '0;
    w_s1_new.id        = w_iid;
    w_s1_new.rd        = issue_instr_i[11:7];
    w_s1_new.op        = op_e'(w_f3[1:0]);
    w_s1_new           = apply_commit(w_s1_new, commit_valid_i, w_cid, commit_kill_i);
    w_buf_new          = apply_commit(r_s1, commit_valid_i, w_cid, commit_kill_i);
    w_buf_new.data     = w_res;
  end

  cvxif_dotp_datapath u_dp (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_ld    (w_issue),
    .i_op    (op_e'(w_f3[1:0])),
    .i_rs1   (issue_rs1_i),
    .i_rs2   (issue_rs2_i),
    .i_s2_op (r_s1.op),
    .o_res   (w_res)
  );

  // Issue is held off for the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_rdy_en <= 1'b0;
    else         r_rdy_en <= 1'b1;
  end

  // Stage-1 entry: load on issue, otherwise hold and track commit/kill.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_s1_vld <= 1'b0;
      r_s1     <= '0;
    end else if (w_issue) begin
      r_s1_vld <= 1'b1;
      r_s1     <= w_s1_new;
    end else begin
      if (w_s1_move) r_s1_vld <= 1'b0;
      r_s1 <= apply_commit(r_s1, commit_valid_i, w_cid, commit_kill_i);
    end
  end

  // Result buffer: commit tracking on all slots, write from stage 1, pop at head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < ResBufDepth; i++) r_buf[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < ResBufDepth; i++)
        r_buf[i] <= apply_commit(r_buf[i], commit_valid_i, w_cid, commit_kill_i);
      if (w_s1_move) begin
        r_buf[r_wp] <= w_buf_new;
        r_wp        <= r_wp + PTR_W'(1);
      end
      if (w_pop) r_rp <= r_rp + PTR_W'(1);
      r_cnt <= r_cnt + CNT_W'(w_s1_move) - CNT_W'(w_pop);
    end
  end

  assign result_valid_o = w_hvld && w_hd.committed && !w_hd.killed;
  assign result_we_o    = result_valid_o;
  assign result_id_o    = result_valid_o ? w_hd.id[IdWidth-1:0] : '0;
  assign result_data_o  = result_valid_o ? w_hd.data : '0;
  assign result_rd_o    = result_valid_o ? w_hd.rd : '0;

endmodule

// File: tb/tb_cvxif_dotp_unit.sv
// Scoreboard bench for cvxif_dotp_unit: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is handed over.
module tb_cvxif_dotp_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        issue_valid_i, issue_ready_o;
  logic [31:0] issue_instr_i;
  logic [2:0]  issue_id_i;
  logic [31:0] issue_rs1_i, issue_rs2_i;
  logic [1:0]  issue_rs_valid_i;
  logic        issue_accept_o, issue_writeback_o;
  logic        commit_valid_i, commit_kill_i;
  logic [2:0]  commit_id_i;
  logic        result_valid_o, result_ready_i, result_we_o;
  logic [2:0]  result_id_o;
  logic [31:0] result_data_o;
  logic [4:0]  result_rd_o;

  cvxif_dotp_unit dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs_valid_i(issue_rs_valid_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_data_o(result_data_o),
    .result_rd_o(result_rd_o), .result_we_o(result_we_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [2:0] id; logic [31:0] data; logic [4:0] rd; } exp_t;
  exp_t sb[$];
  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 5'd2, 5'd1, f3, rd, 7'b0001011};
  endfunction

  // Monitor: every handed-over result must match the oldest expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (rst_ni && result_valid_o && result_ready_i) begin
      if (sb.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("res_id", 32'(result_id_o), 32'(e.id));
        chk("res_data", result_data_o, e.data);
        chk("res_rd", 32'(result_rd_o), 32'(e.rd));
        chk("res_we", 32'(result_we_o), 32'd1);
      end
    end
  end

  task automatic sync();
    @(posedge clk_i); #1;
  endtask

  // Drive one issue (optionally committed in the same cycle); wait bounded for ready.
  task automatic issue(input logic [31:0] instr, input logic [2:0] id,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit cmt, input bit exp_acc, input bit push,
                       input logic [31:0] exp_d, output int waited);
    int n;
    n = 0;
    issue_valid_i = 1'b1; issue_instr_i = instr; issue_id_i = id;
    issue_rs1_i = a; issue_rs2_i = b; issue_rs_valid_i = 2'b11;
    commit_valid_i = cmt; commit_id_i = id; commit_kill_i = 1'b0;
    @(negedge clk_i);
    while (!issue_ready_o && n < 50) begin @(negedge clk_i); n++; end
    chk("issue_ready_wait", 32'(n < 50), 32'd1);
    chk("issue_accept", 32'(issue_accept_o), 32'(exp_acc));
    chk("issue_writeback", 32'(issue_writeback_o), 32'(exp_acc));
    if (push) sb.push_back('{id, exp_d, instr[11:7]});
    waited = n;
    sync();
    issue_valid_i = 1'b0; commit_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [2:0] id, input bit kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
    sync();
    commit_valid_i = 1'b0; commit_kill_i = 1'b0;
  endtask

  initial begin
    int w;
    issue_valid_i = 0; issue_instr_i = 0; issue_id_i = 0; issue_rs1_i = 0;
    issue_rs2_i = 0; issue_rs_valid_i = 2'b11; commit_valid_i = 0;
    commit_id_i = 0; commit_kill_i = 0; result_ready_i = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ready", 32'(issue_ready_o), 32'd0);
    chk("rst_valid", 32'(result_valid_o), 32'd0);
    chk("rst_data", result_data_o, 32'd0);
    rst_ni = 1'b1;
    #1 chk("ready_before_edge", 32'(issue_ready_o), 32'd0);
    sync();
    chk("ready_after_edge", 32'(issue_ready_o), 32'd1);

    // DOTP4 signed: 2 - 1 + 6 - 1 = 6, result two cycles after accept
    issue(mk(3'd0, 5'd5), 3'd0, 32'hFF02FF01, 32'h01030102, 1, 1, 1, 32'd6, w);
    @(negedge clk_i) chk("latency_n1", 32'(result_valid_o), 32'd0);
    @(negedge clk_i) chk("latency_n2", 32'(result_valid_o), 32'd1);
    sync();

    // Back-to-back stream: DOTP4U, RELU x2, negative DOTP4, two foreign instrs
    issue(mk(3'd1, 5'd6), 3'd1, 32'hFF02FF01, 32'h01030102, 1, 1, 1, 32'd518, w);
    issue(mk(3'd2, 5'd7), 3'd2, 32'h80000000, 32'h0, 1, 1, 1, 32'd0, w);
    issue(mk(3'd2, 5'd8), 3'd3, 32'h12345678, 32'h0, 1, 1, 1, 32'h12345678, w);
    issue(mk(3'd0, 5'd9), 3'd4, 32'h80808080, 32'h7F7F7F7F, 1, 1, 1, 32'hFFFF0200, w);
    issue(32'h00000033, 3'd5, 32'h1, 32'h1, 1, 0, 0, 32'd0, w);
    issue(mk(3'd0, 5'd9) | 32'h02000000, 3'd5, 32'h1, 32'h1, 1, 0, 0, 32'd0, w);
    repeat (4) sync();

    // Backpressure: third issue blocked until the first result pops
    result_ready_i = 1'b0;
    issue(mk(3'd0, 5'd10), 3'd0, 32'hFF02FF01, 32'h01030102, 1, 1, 1, 32'd6, w);
    issue(mk(3'd1, 5'd11), 3'd1, 32'hFF02FF01, 32'h01030102, 1, 1, 1, 32'd518, w);
    issue_valid_i = 1'b1; issue_instr_i = mk(3'd2, 5'd12); issue_id_i = 3'd2;
    issue_rs1_i = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("full_ready_low", 32'(issue_ready_o), 32'd0);
      chk("hold_valid", 32'(result_valid_o), 32'd1);
      chk("hold_data", result_data_o, 32'd6);
    end
    sync();
    result_ready_i = 1'b1;
    issue(mk(3'd2, 5'd12), 3'd2, 32'h12345678, 32'h0, 1, 1, 1, 32'h12345678, w);
    chk("ready_with_pop", 32'(w), 32'd0);
    repeat (4) sync();

    // Kill: ids 0,1,2 with 1 killed after issue -> results for 0 and 2 only
    issue(mk(3'd0, 5'd13), 3'd0, 32'h01010101, 32'h02020202, 0, 1, 1, 32'd8, w);
    issue(mk(3'd1, 5'd14), 3'd1, 32'h01010101, 32'h02020202, 0, 1, 0, 32'd0, w);
    @(negedge clk_i) chk("uncommitted_no_valid", 32'(result_valid_o), 32'd0);
    sync();
    commit(3'd0, 0);
    commit(3'd1, 1);
    issue(mk(3'd2, 5'd15), 3'd2, 32'h7FFFFFFF, 32'h0, 1, 1, 1, 32'h7FFFFFFF, w);
    repeat (4) sync();

    // Reset mid-operation drops the in-flight entry; later commit is ignored
    issue(mk(3'd0, 5'd16), 3'd3, 32'h01010101, 32'h01010101, 0, 1, 0, 32'd0, w);
    rst_ni = 1'b0;
    sync();
    chk("midrst_valid", 32'(result_valid_o), 32'd0);
    rst_ni = 1'b1;
    sync();
    commit(3'd3, 0);
    for (int i = 0; i < 3; i++)
      @(negedge clk_i) chk("post_rst_no_result", 32'(result_valid_o), 32'd0);
    sync();

`ifdef CVXIF_DOTP_SAT_EN
    issue(mk(3'd3, 5'd17), 3'd4, 32'h7F7F7F7F, 32'h7F7F7F7F, 1, 1, 1, 32'd127, w);
`else
    issue(mk(3'd3, 5'd17), 3'd4, 32'h7F7F7F7F, 32'h7F7F7F7F, 1, 0, 0, 32'd0, w);
`endif

    for (int i = 0; i < 50 && sb.size() != 0; i++) sync();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
